rv_multicycle_core: RTL
=======================

# rv_multicycle_core

Multi-cycle successor to the single-cycle reduced RISC-V top. It executes a reduced RV32 subset through a FETCH/DECODE/EXEC/MEM/WB state machine and talks to instruction and data memory over req/ack handshakes with variable latency. It adds load/store, `jal`, `lui`, an RV32E-style configurable register count, and a sticky halt on illegal or misaligned operations. It sits at the top of the CPU, in place of the single-cycle datapath, and drives external memory models.

## Interface
Parameters:
- `DW`, 32: datapath and register width. Only 32 is legal; elaboration error otherwise.
- `ADDR_W`, 32: memory address width. Must be ≤ DW; addresses are the low ADDR_W bits of computed values.
- `NREGS`, 32: architectural registers, 16 or 32.
- `RESET_PC`, 0: PC after reset. Must be word aligned.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `imem_req` output 1: instruction fetch request.
- `imem_addr` output ADDR_W: fetch address, equal to PC.
- `imem_ack` input 1: fetch complete; `imem_rdata` is valid this cycle.
- `imem_rdata` input 32: instruction word.
- `dmem_req` output 1: data access request.
- `dmem_we` output 1: 1 for store, 0 for load.
- `dmem_addr` output ADDR_W: word-aligned data address.
- `dmem_wdata` output DW: store data.
- `dmem_ack` input 1: access complete; `dmem_rdata` is valid for loads.
- `dmem_rdata` input DW: load data.
- `a0out` output DW: live value of x10.
- `pc_out` output ADDR_W: PC of the instruction in flight.
- `retire` output 1: one-cycle pulse per completed instruction.
- `halted` output 1: sticky halt flag.

## Operation
- Supported instructions:
  - R-type: add, sub, and, or, slt (signed).
  - I-type: addi, lw.
  - S-type: sw.
  - B-type: beq, bne.
  - jal.
  - lui.
- Immediates are sign-extended per RV32I format. Branch and jal offsets are PC-relative.
- Illegal conditions, each causing transition to HALT:
  - any other opcode or funct;
  - any register index ≥ NREGS;
  - load/store address[1:0] ≠ 0;
  - taken branch or jal target[1:0] ≠ 0.
- HALT behaviour: `halted`=1, no requests issued, no further register or PC writes. The illegal instruction does not retire. HALT is left only by reset.
- Register file: NREGS×DW. x0 reads 0 and writes to it are discarded. `a0out` reflects x10 combinationally from the register array.
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
  - IDLE → FETCH: unconditional, one cycle after reset release.
  - FETCH: `imem_req`=1, `imem_addr`=PC. On an edge with `imem_ack`=1, latch the instruction and go to DECODE.
  - DECODE: read rs1/rs2, form the immediate, check legality. Illegal → HALT, otherwise → EXEC.
  - EXEC: compute ALU result, branch decision and next PC. lw/sw → MEM; all others → WB. Misaligned address or target → HALT.
  - MEM: hold `dmem_req`=1 with stable addr/we/wdata until an edge with `dmem_ack`=1. Latch load data, then → WB.
  - WB:
    - write rd for R-type, addi, lw, lui, and jal (jal writes PC+4);
    - PC ← next PC (branch/jal target or PC+4);
    - pulse `retire`;
    - → FETCH.
- Arithmetic: modulo 2^32; PC increments wrap at 2^ADDR_W. slt compares signed and yields 0/1.

## Timing
- Reset values:
  - state=IDLE, PC=RESET_PC, all registers 0;
  - `imem_req`=`dmem_req`=`dmem_we`=0, `retire`=0, `halted`=0;
  - `a0out`=0, `pc_out`=RESET_PC;
  - `imem_addr`=RESET_PC, `dmem_addr`=0, `dmem_wdata`=0.
- All request outputs are pure functions of registered state, with no combinational path from ack to req.
- Handshake rules:
  - A req stays high with stable payload until the ack edge.
  - The req deasserts in the cycle after the ack.
  - Ack is allowed in the same cycle req first rises (zero wait).
  - Ack while req is low is ignored.
- Latency with zero-wait memory, from FETCH entry to the `retire` pulse:
  - ALU, branch, jal, lui: 4 cycles;
  - lw/sw: 5 cycles.
  - Each wait cycle on a memory adds 1 cycle.
- The `retire` pulse coincides with the WB cycle. The register write and PC update are visible on the following edge.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). An outstanding request is abandoned, and a later ack is ignored.

## Test plan
- addi x10,x0,5; addi x10,x10,-2 with zero-wait memory → `a0out`=3 after the second retire; retire pulses 4 cycles apart.
- sw x10,8(x0) then lw x11,8(x0) with 3-cycle dmem latency; x10=0xDEADBEEF → store issued with addr 8, `dmem_we`=1; load then x11=0xDEADBEEF; each instruction takes 8 cycles.
- Loop `addi x10,x10,1; bne x10,x5,-4` with x5=5 → exactly 10 retires; final `a0out`=5, PC=RESET_PC+8.
- jal x1,+12 at PC 0x10 → x1=0x14, next fetch at 0x1C. addi x0,x0,7 → x0 still 0.
- Opcode 0x7F, or lw from address 0x6, or NREGS=16 with rd=x20 → `halted`=1, no retire, no further `imem_req` for 20 cycles.
- Reset asserted during MEM with `dmem_req` high, ack arriving 2 cycles later → `dmem_req`=0 immediately, ack ignored, first fetch after release at RESET_PC.

Source files
------------

// File: rtl/rv_multicycle_core.sv
// rtl/rv_multicycle_core.sv - multi-cycle reduced RV32 core with req/ack instruction and data ports
module rv_multicycle_core #(
    parameter int                DW       = 32,
    parameter int                ADDR_W   = 32,
    parameter int                NREGS    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DW-1:0]     dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DW-1:0]     dmem_rdata,
    output logic [DW-1:0]     a0out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              retire,
    output logic              halted
);

    generate
        if (DW != 32) begin : g_bad_dw
            $error("rv_multicycle_core: DW must be 32");
        end
        if (ADDR_W > DW) begin : g_bad_aw
            $error("rv_multicycle_core: ADDR_W must not exceed DW");
        end
        if (NREGS != 16 && NREGS != 32) begin : g_bad_nregs
            $error("rv_multicycle_core: NREGS must be 16 or 32");
        end
        if (RESET_PC[1:0] != 2'b00) begin : g_bad_pc
            $error("rv_multicycle_core: RESET_PC must be word aligned");
        end
    endgenerate

    localparam int RW = (NREGS == 16) ? 4 : 5;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t            state;
    logic [31:0]       instr;
    logic [DW-1:0]     regs [NREGS];
    logic [DW-1:0]     rs1v, rs2v, imm, res;
    logic [ADDR_W-1:0] pc, next_pc;

    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

    logic is_r, is_addi, is_lw, is_sw, is_br, is_jal, is_lui;
    logic uses_rd, uses_rs1, uses_rs2, legal;
    logic [DW-1:0] imm_d, sum, alu_out;
    logic [ADDR_W-1:0] tgt, pc4;
    logic take, misalign;

    function automatic logic reg_ok(input logic [4:0] r);
        return (NREGS == 32) || !r[4];
    endfunction

    always_comb begin
        is_r    = (opcode == 7'b0110011) &&
                  ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010)) ||
                   (f7 == 7'b0100000 && f3 == 3'b000));
        is_addi = (opcode == 7'b0010011) && (f3 == 3'b000);
        is_lw   = (opcode == 7'b0000011) && (f3 == 3'b010);
        is_sw   = (opcode == 7'b0100011) && (f3 == 3'b010);
        is_br   = (opcode == 7'b1100011) && (f3 == 3'b000 || f3 == 3'b001);
        is_jal  = (opcode == 7'b1101111);
        is_lui  = (opcode == 7'b0110111);

        uses_rd  = is_r | is_addi | is_lw | is_jal | is_lui;
        uses_rs1 = is_r | is_addi | is_lw | is_sw | is_br;
        uses_rs2 = is_r | is_sw | is_br;
        legal    = (is_r | is_addi | is_lw | is_sw | is_br | is_jal | is_lui) &&
                   !(uses_rd && !reg_ok(rd)) && !(uses_rs1 && !reg_ok(rs1)) && !(uses_rs2 && !reg_ok(rs2));

        if (is_sw)
            imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        else if (is_br)
            imm_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        else if (is_jal)
            imm_d = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        else if (is_lui)
            imm_d = {instr[31:12], 12'b0};
        else
            imm_d = {{20{instr[31]}}, instr[31:20]};

        // EXEC-stage datapath works on operands captured in DECODE
        sum = rs1v + imm;
        tgt = pc + imm[ADDR_W-1:0];
        pc4 = pc + ADDR_W'(4);
        alu_out = sum;
        if (is_r) begin
            case ({f7[5], f3})
                4'b1000: alu_out = rs1v - rs2v;
                4'b0111: alu_out = rs1v & rs2v;
                4'b0110: alu_out = rs1v | rs2v;
                4'b0010: alu_out = {{(DW-1){1'b0}}, $signed(rs1v) < $signed(rs2v)};
                default: alu_out = rs1v + rs2v;
            endcase
        end else if (is_lui) begin
            alu_out = imm;
        end else if (is_jal) begin
            alu_out = DW'(pc4);
        end

        take     = is_jal | (is_br & ((rs1v == rs2v) ^ f3[0]));
        misalign = ((is_lw | is_sw) && sum[1:0] != 2'b00) || (take && tgt[1:0] != 2'b00);
    end

    assign imem_addr = pc;
    assign pc_out    = pc;
    assign a0out     = regs[10];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            next_pc    <= RESET_PC;
            instr      <= '0;
            rs1v       <= '0;
            rs2v       <= '0;
            imm        <= '0;
            res        <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            retire     <= 1'b0;
            halted     <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!legal) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        rs1v  <= regs[rs1[RW-1:0]];
                        rs2v  <= regs[rs2[RW-1:0]];
                        imm   <= imm_d;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (misalign) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (is_lw | is_sw) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_sw;
                        dmem_addr  <= sum[ADDR_W-1:0];
                        dmem_wdata <= rs2v;
                        next_pc    <= pc4;
                        state      <= S_MEM;
                    end else begin
                        res     <= alu_out;
                        next_pc <= take ? tgt : pc4;
                        retire  <= 1'b1;
                        state   <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (is_lw) res <= dmem_rdata;
                        retire   <= 1'b1;
                        state    <= S_WB;
                    end
                end
                S_WB: begin
                    if (uses_rd && rd != 5'd0) regs[rd[RW-1:0]] <= res;
                    pc       <= next_pc;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule
